// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared types and constants for the ALU scheduler
package alu_sched_pkg;

    localparam int DEF_W = 32;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_SHR = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter, combinational
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_scheduler.sv
// rtl/alu_scheduler.sv - shares one registered ALU between two requesters, round-robin
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [1:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [1:0]   req1_op,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [W-1:0] rsp0_data,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp1_data,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_op,
    input  logic [W-1:0] alu_c,
    output logic         busy
);

    state_t         r_state;
    logic           r_last;
    logic           r_owner;
    logic [W-1:0]   r_alu_a;
    logic [W-1:0]   r_alu_b;
    logic [1:0]     r_alu_op;
    logic           r_rsp0_valid;
    logic           r_rsp1_valid;
    logic [W-1:0]   r_rsp0_data;
    logic [W-1:0]   r_rsp1_data;

    logic [1:0]     w_grant;
    logic           w_idle;
    logic           w_accept;
    logic           w_rsp_done;

    rr_arb2 u_arb (
        .req   ({req1_valid, req0_valid}),
        .last  (r_last),
        .grant (w_grant)
    );

    assign w_idle     = (r_state == IDLE);
    assign w_accept   = w_idle && (w_grant != 2'b00);
    assign w_rsp_done = r_owner ? rsp1_ready : rsp0_ready;

    assign req0_ready = w_idle && w_grant[0] && !rst;
    assign req1_ready = w_idle && w_grant[1] && !rst;

    // Operands go straight into the ALU-facing registers on accept, so they
    // are presented throughout ISSUE and then held until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last       <= 1'b1;
            r_owner      <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= OP_ADD;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_data  <= '0;
            r_rsp1_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_owner  <= w_grant[1];
                        r_last   <= w_grant[1];
                        r_alu_a  <= w_grant[1] ? req1_a  : req0_a;
                        r_alu_b  <= w_grant[1] ? req1_b  : req0_b;
                        r_alu_op <= w_grant[1] ? req1_op : req0_op;
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_state <= CAPTURE;
                end
                CAPTURE: begin
                    if (r_owner) begin
                        r_rsp1_data  <= alu_c;
                        r_rsp1_valid <= 1'b1;
                    end else begin
                        r_rsp0_data  <= alu_c;
                        r_rsp0_valid <= 1'b1;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    if (w_rsp_done) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_data  = r_rsp0_data;
    assign rsp1_data  = r_rsp1_data;
    assign busy       = !w_idle;

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Two-port scheduler that shares one registered 32-bit ALU (2-bit opcode: add, sub, shift-left, shift-right; result registered one clock after operands are presented) between two independent requesters. Each requester hands over an operand pair and opcode through a valid/ready request channel and receives its result on a private valid/ready response channel. Round-robin arbitration, one operation in flight at a time. Sits between the requesting blocks and the ALU instance; it is the only driver of the ALU's operand and opcode inputs.

## Interface
- W, 32, operand/result width; must match the ALU width.
- clk  in  1  rising-edge clock, shared with the ALU.
- rst  in  1  synchronous, active-high reset.
- reqN_valid  in  1  requester N (N = 0, 1) presents an operation.
- reqN_ready  out  1  scheduler accepts requester N's operation this cycle.
- reqN_a, reqN_b  in  W  operands.
- reqN_op  in  2  opcode: 00 add, 01 sub, 10 shl, 11 shr.
- rspN_valid  out  1  result for requester N is available.
- rspN_ready  in  1  requester N consumes the result.
- rspN_data  out  W  result.
- alu_a, alu_b  out  W  ALU operand inputs.
- alu_op  out  2  ALU opcode input.
- alu_c  in  W  ALU registered output.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: the arbiter picks a grant from the valid requests. If only one is valid, grant it. If both are valid, grant the one not granted last (`last` pointer). `reqN_ready = (state == IDLE) && grant == N`. On the accept edge:
  - latch a, b, op and the owner id;
  - update `last` to the owner;
  - go to ISSUE.
- ISSUE: drive `alu_a`, `alu_b` and `alu_op` from the latched values. The ALU registers the result on this edge. Go to CAPTURE.
- CAPTURE: `alu_c` holds the result. Latch it into the owner's `rspN_data`. Go to RESP.
- RESP: assert `rsp<owner>_valid`. Hold data stable until the `rspN_ready` edge, then return to IDLE. The other response channel stays 0.
- `alu_a`, `alu_b` and `alu_op` hold their last driven value outside ISSUE. `alu_c` is ignored outside CAPTURE.
- Arithmetic belongs to the ALU and the scheduler does not alter it:
  - sub wraps modulo 2^W;
  - shifts use the full `alu_b` value, so any shift amount ≥ W yields 0.
- The scheduler never reorders or drops an accepted operation, except on reset.

## Timing
- Reset values:
  - state IDLE;
  - `last` = 1, so requester 0 wins the first tie;
  - `rspN_valid` = 0, `rspN_data` = 0;
  - `alu_a`, `alu_b`, `alu_op` = 0;
  - `busy` = 0.
- `reqN_ready` is 0 while `rst` is high.
- Latency: accept edge at cycle 0 gives `rspN_valid` = 1 in cycle 3, counting from the accept edge.
- Minimum issue interval: 4 cycles, with `rspN_ready` held high.
- Response back-pressure: RESP is held indefinitely. Both `reqN_ready` stay 0 meanwhile.
- A request that drops `valid` before acceptance is never granted. No acceptance happens without `valid` and `ready` high on the same edge.
- Simultaneous events: `rspN_ready` in RESP and new `req` valids are not accepted in the same cycle. The new request is accepted in the following IDLE cycle.
- Reset mid-operation: returns to IDLE in the next cycle. The in-flight operation is discarded and no response is produced. `last` resets to 1.

## Structure
- Package `alu_sched_pkg`:
  - state enum (IDLE, ISSUE, CAPTURE, RESP);
  - opcode localparams OP_ADD, OP_SUB, OP_SHL, OP_SHR;
  - default W.
- Sub-module `rr_arb2`: a 2-input round-robin arbiter.
  - Inputs: `req[1:0]`, `last`.
  - Output: one-hot `grant[1:0]`.
  - Combinational.
  - The `last` register stays in `alu_scheduler`.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- After reset, apply req0 with a=5, b=3, op=00. Required: `reqN_ready`, `alu_*` and `busy` show their reset values; `rsp0_valid` goes high 3 cycles after accept with `rsp0_data` = 8; `rsp1_valid` stays 0.
- Apply req1 with a=3, b=5, op=01. Required: `rsp1_data` = 0xFFFFFFFE, showing wrap-around.
- Apply req0 with a=1, b=31, op=10, then req0 with a=0x80000000, b=32, op=11. Required: results 0x80000000 and 0x00000000.
- Hold both requesters valid continuously with distinct operands and keep `rspN_ready` = 1. Required: grants alternate 0,1,0,1 starting with 0, and one result arrives every 4 cycles.
- Hold `rsp0_ready` = 0 for 10 cycles in RESP while req1 is valid. Required: `rsp0_data` stable, `req1_ready` = 0 throughout, and req1 accepted the cycle after the `rsp0_ready` handshake plus IDLE.
- Assert `rst` for one cycle in CAPTURE. Required: no `rspN_valid` ever appears for that operation, `busy` = 0 the next cycle, and the next request is serviced normally.
